// File: rtl/player_feedback.sv
// LED feedback driver for four player controllers: accepts one result command at a
// time and plays solid, blinking or latched lockout patterns on the green/red LEDs.

module player_feedback_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_acc,
  input  logic [1:0] i_code,
  input  logic       i_sel_cmd,
  input  logic       i_sel_act,
  input  logic       i_clr,
  input  logic       i_red_off,
  input  logic       i_red_on,
  output logic       o_green,
  output logic       o_red
);
  localparam logic [1:0] CODE_CLEAR   = 2'b00;
  localparam logic [1:0] CODE_CORRECT = 2'b01;
  localparam logic [1:0] CODE_WRONG   = 2'b10;
  localparam logic [1:0] CODE_LOCKOUT = 2'b11;

  logic r_green;
  logic r_red;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_green <= 1'b0;
      r_red   <= 1'b0;
    end else if (i_clr) begin
      r_green <= 1'b0;
      r_red   <= 1'b0;
    end else if (i_acc) begin
      case (i_code)
        CODE_CLEAR: begin
          r_green <= 1'b0;
          r_red   <= 1'b0;
        end
        CODE_CORRECT: begin
          r_green <= i_sel_cmd;
          r_red   <= 1'b0;
        end
        CODE_WRONG: begin
          r_green <= 1'b0;
          r_red   <= i_sel_cmd;
        end
        CODE_LOCKOUT: begin
          r_green <= i_sel_cmd;
          r_red   <= ~i_sel_cmd;
        end
        default: begin
          r_green <= 1'b0;
          r_red   <= 1'b0;
        end
      endcase
    end else if (i_red_off) begin
      r_red <= 1'b0;
    end else if (i_red_on) begin
      r_red <= i_sel_act;
    end
  end

  assign o_green = r_green;
  assign o_red   = r_red;
endmodule

module player_feedback #(
  parameter int TICK_DIV    = 50000,
  parameter int SOLID_MS    = 1000,
  parameter int BLINK_MS    = 125,
  parameter int BLINK_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmdValid,
  input  logic [1:0] cmdPlayer,
  input  logic [1:0] cmdCode,
  input  logic       cmdAbort,
  output logic       cmdReady,
  output logic       busy,
  output logic [3:0] greenLed,
  output logic [3:0] redLed
);
  localparam int NUM_PLAYERS = 4;
  localparam int MAX_MS = (SOLID_MS > BLINK_MS) ? SOLID_MS : BLINK_MS;
  localparam int PW = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
  localparam int TW = (MAX_MS > 1)      ? $clog2(MAX_MS)      : 1;
  localparam int BW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] SOLID_LAST = TW'(SOLID_MS - 1);
  localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_MS - 1);
  localparam logic [BW-1:0] BC_LAST    = BW'(BLINK_COUNT - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SOLID     = 2'd1;
  localparam logic [1:0] S_BLINK_ON  = 2'd2;
  localparam logic [1:0] S_BLINK_OFF = 2'd3;

  localparam logic [1:0] CODE_CORRECT = 2'b01;
  localparam logic [1:0] CODE_WRONG   = 2'b10;

  logic [1:0]    r_state;
  logic [PW-1:0] r_pre;
  logic [TW-1:0] r_tcnt;
  logic [BW-1:0] r_bcnt;
  logic [1:0]    r_player;

  logic       w_idle;
  logic       w_acc;
  logic       w_tick;
  logic       w_solid_done;
  logic       w_half_done;
  logic       w_blink_done;
  logic       w_clr;
  logic       w_red_off;
  logic       w_red_on;
  logic [1:0] w_state_nxt;
  logic [3:0] w_sel_cmd;
  logic [3:0] w_sel_act;
  logic [3:0] w_green;
  logic [3:0] w_red;

  assign w_idle  = (r_state == S_IDLE);
  assign w_acc   = cmdValid & w_idle & ~cmdAbort;
  assign w_tick  = (r_pre == PRE_LAST);

  // A timed state ends on the tick that completes its last tick period.
  assign w_solid_done = (r_state == S_SOLID) & w_tick & (r_tcnt == SOLID_LAST);
  assign w_half_done  = ((r_state == S_BLINK_ON) | (r_state == S_BLINK_OFF))
                        & w_tick & (r_tcnt == BLINK_LAST);
  assign w_blink_done = (r_state == S_BLINK_OFF) & w_half_done & (r_bcnt == BC_LAST);

  assign w_clr     = cmdAbort | w_solid_done | w_blink_done;
  assign w_red_off = (r_state == S_BLINK_ON) & w_half_done;
  assign w_red_on  = (r_state == S_BLINK_OFF) & w_half_done & ~w_blink_done;

  assign w_sel_cmd = 4'b0001 << cmdPlayer;
  assign w_sel_act = 4'b0001 << r_player;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (cmdCode == CODE_CORRECT)    w_state_nxt = S_SOLID;
          else if (cmdCode == CODE_WRONG) w_state_nxt = S_BLINK_ON;
        end
      end
      S_SOLID:     if (w_solid_done) w_state_nxt = S_IDLE;
      S_BLINK_ON:  if (w_half_done)  w_state_nxt = S_BLINK_OFF;
      S_BLINK_OFF: if (w_half_done)  w_state_nxt = w_blink_done ? S_IDLE : S_BLINK_ON;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pre    <= '0;
      r_tcnt   <= '0;
      r_bcnt   <= '0;
      r_player <= '0;
    end else if (cmdAbort) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
    end else if (w_idle) begin
      // Counters stay parked at zero so a new pattern starts on an exact cycle count.
      r_state <= w_state_nxt;
      r_pre   <= '0;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      if (w_acc) r_player <= cmdPlayer;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_tick ? '0 : r_pre + 1'b1;
      if (w_state_nxt != r_state) r_tcnt <= '0;
      else if (w_tick)            r_tcnt <= r_tcnt + 1'b1;
      if (w_blink_done)  r_bcnt <= '0;
      else if (w_red_on) r_bcnt <= r_bcnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_lane
    player_feedback_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_acc     (w_acc),
      .i_code    (cmdCode),
      .i_sel_cmd (w_sel_cmd[g]),
      .i_sel_act (w_sel_act[g]),
      .i_clr     (w_clr),
      .i_red_off (w_red_off),
      .i_red_on  (w_red_on),
      .o_green   (w_green[g]),
      .o_red     (w_red[g])
    );
  end

  assign cmdReady = w_idle;
  assign busy     = ~w_idle;
  assign greenLed = w_green;
  assign redLed   = w_red;
endmodule

// File: tb/tb_player_feedback.sv
// Scoreboard bench for player_feedback: stimulus pushes per-cycle expected LED and
// handshake values tagged with a cycle number; a negedge monitor pops and compares.

module tb_player_feedback;
  localparam int TICK_DIV    = 4;
  localparam int SOLID_MS    = 3;
  localparam int BLINK_MS    = 2;
  localparam int BLINK_COUNT = 2;
  localparam int SOLID_CYC   = SOLID_MS * TICK_DIV;
  localparam int HALF_CYC    = BLINK_MS * TICK_DIV;

  typedef struct {
    int         cyc;
    int         tid;
    logic [3:0] g;
    logic [3:0] r;
    logic       rdy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmdValid;
  logic [1:0] cmdPlayer;
  logic [1:0] cmdCode;
  logic       cmdAbort;
  logic       cmdReady;
  logic       busy;
  logic [3:0] greenLed;
  logic [3:0] redLed;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   tid    = 0;

  player_feedback #(
    .TICK_DIV(TICK_DIV), .SOLID_MS(SOLID_MS), .BLINK_MS(BLINK_MS), .BLINK_COUNT(BLINK_COUNT)
  ) dut (
    .clk(clk), .rst(rst), .cmdValid(cmdValid), .cmdPlayer(cmdPlayer), .cmdCode(cmdCode),
    .cmdAbort(cmdAbort), .cmdReady(cmdReady), .busy(busy), .greenLed(greenLed), .redLed(redLed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are presented every cycle; compare whatever is due now.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_chk++;
      $display("FAIL t%0d missed check at cyc %0d (now %0d)", q[0].tid, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (greenLed === e.g && redLed === e.r && cmdReady === e.rdy && busy === ~e.rdy)
        n_pass++;
      else
        $display("FAIL t%0d cyc %0d got g=%b r=%b rdy=%b busy=%b exp g=%b r=%b rdy=%b busy=%b",
                 e.tid, cyc, greenLed, redLed, cmdReady, busy, e.g, e.r, e.rdy, ~e.rdy);
    end
  end

  // Drive one clock's worth of inputs and queue the outputs expected after that edge.
  task automatic step(input logic v, input logic [1:0] p, input logic [1:0] c,
                      input logic ab, input logic rs,
                      input logic [3:0] eg, input logic [3:0] er, input logic erdy);
    exp_t e;
    rst = rs; cmdValid = v; cmdPlayer = p; cmdCode = c; cmdAbort = ab;
    e.cyc = cyc + 1; e.tid = tid; e.g = eg; e.r = er; e.rdy = erdy;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [3:0] eg, input logic [3:0] er, input logic erdy);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, eg, er, erdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmdValid = 1'b0; cmdPlayer = 2'b00; cmdCode = 2'b00; cmdAbort = 1'b0;
    @(posedge clk); #1;

    tid = 1;
    repeat (2) step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1);
    idle(4'b0000, 4'b0000, 1'b1);

    tid = 2;
    step(1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0);
    repeat (SOLID_CYC - 1) idle(4'b0100, 4'b0000, 1'b0);
    idle(4'b0000, 4'b0000, 1'b1);
    idle(4'b0000, 4'b0000, 1'b1);

    tid = 3;
    step(1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0);
    repeat (HALF_CYC - 1) idle(4'b0000, 4'b0001, 1'b0);
    repeat (HALF_CYC)     idle(4'b0000, 4'b0000, 1'b0);
    repeat (HALF_CYC)     idle(4'b0000, 4'b0001, 1'b0);
    repeat (HALF_CYC)     idle(4'b0000, 4'b0000, 1'b0);
    idle(4'b0000, 4'b0000, 1'b1);

    tid = 4;
    step(1'b1, 2'b11, 2'b11, 1'b0, 1'b0, 4'b1000, 4'b0111, 1'b1);
    repeat (99) idle(4'b1000, 4'b0111, 1'b1);
    step(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
    idle(4'b0000, 4'b0000, 1'b1);

    tid = 5;
    step(1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    repeat (4) idle(4'b0001, 4'b0000, 1'b0);
    step(1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0);
    idle(4'b0001, 4'b0000, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1);
    idle(4'b0000, 4'b0000, 1'b1);

    tid = 6;
    step(1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0);
    repeat (3) idle(4'b0100, 4'b0000, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1);
    idle(4'b0000, 4'b0000, 1'b1);
    step(1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1);
    idle(4'b0000, 4'b0000, 1'b1);

    // Lockout replaced by a new command, then abort from the middle of a blink-off phase.
    tid = 7;
    step(1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 4'b0001, 4'b1110, 1'b1);
    step(1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b0);
    repeat (HALF_CYC - 1) idle(4'b0000, 4'b0010, 1'b0);
    repeat (3)            idle(4'b0000, 4'b0000, 1'b0);
    step(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1);
    idle(4'b0000, 4'b0000, 1'b1);

    // Lockout cleared by abort while idle.
    tid = 8;
    step(1'b1, 2'b10, 2'b11, 1'b0, 1'b0, 4'b0100, 4'b1011, 1'b1);
    idle(4'b0100, 4'b1011, 1'b1);
    step(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1);
    idle(4'b0000, 4'b0000, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain got %0d pending required 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
